// File: rtl/bch_dec_seq.sv
// BCH(15,7,t=2) sequential decode controller over GF(16), primitive polynomial x^4+x+1.
// Latency: out_valid rises 16 edges after accept (zero S1) or 17 edges (Chien path).
// Backpressure: one word in flight; in_ready only in IDLE, and the result is held in OUT until out_ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        received-word handshake, in_codeword[14:0] (bit i = coeff of x^i)
//   lambda1/lambda2          registered error-locator coefficients driven to the external Chien block
//   chien_error_vector/found Chien result, sampled at the end of the CHIEN cycle
//   out_valid/out_ready      result handshake with out_codeword, out_data (= out_codeword[14:8]), out_status
//   out_status               0 clean, 1 one error fixed, 2 two errors fixed, 3 uncorrectable
// Optional: define BCH_DEC_STATS_EN to add saturating cnt_corrected / cnt_uncorrectable outputs.

module bch_dec_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] in_codeword,
    output logic [3:0]  lambda1,
    output logic [3:0]  lambda2,
    input  logic [14:0] chien_error_vector,
    input  logic        chien_error_found,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [14:0] out_codeword,
    output logic [6:0]  out_data,
    output logic [1:0]  out_status
`ifdef BCH_DEC_STATS_EN
    ,
    output logic [15:0] cnt_corrected,
    output logic [15:0] cnt_uncorrectable
`endif
);

    localparam int N = 15;
    localparam int K = 7;

    // GF(16) multiply: shift-and-add, reducing x^4 to x+1.
    function automatic logic [3:0] gf_mult(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    // a^e for small exponents (e < 15).
    function automatic logic [3:0] gf_pow(input logic [3:0] a, input logic [3:0] e);
        logic [3:0] p;
        p = 4'h1;
        for (int i = 0; i < 15; i++) begin
            if (i < int'(e)) p = gf_mult(p, a);
        end
        return p;
    endfunction

    function automatic logic [3:0] popcount15(input logic [14:0] v);
        logic [3:0] c;
        c = 4'h0;
        for (int i = 0; i < 15; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYND  = 3'd1,
        CALC  = 3'd2,
        CHIEN = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [N-1:0] r;
    logic [3:0]   s1;
    logic [3:0]   s3;
    logic [3:0]   cnt;

    // Locator math for the CALC cycle. S1^-1 = S1^14 = S1^2 * S1^4 * S1^8.
    logic [3:0] s1_sq;
    logic [3:0] s1_p4;
    logic [3:0] s1_p8;
    logic [3:0] s1_inv;
    logic [3:0] s1_cube;
    logic [3:0] lam2_calc;

    always_comb begin
        s1_sq     = gf_mult(s1, s1);
        s1_p4     = gf_mult(s1_sq, s1_sq);
        s1_p8     = gf_mult(s1_p4, s1_p4);
        s1_inv    = gf_mult(gf_mult(s1_sq, s1_p4), s1_p8);
        s1_cube   = gf_pow(s1, 4'd3);
        lam2_calc = gf_mult(s3 ^ s1_cube, s1_inv);
    end

    // Chien outcome: the locator degree tells how many roots must be found;
    // any other count means the error pattern is beyond t=2.
    logic [1:0] exp_roots;
    logic       root_match;

    always_comb begin
        exp_roots  = (lambda2 == 4'h0) ? 2'd1 : 2'd2;
        root_match = chien_error_found &&
                     (popcount15(chien_error_vector) == {2'b00, exp_roots});
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = SYND;
            SYND:    if (cnt == 4'd0) next_state = CALC;
            CALC:    next_state = (s1 == 4'h0) ? OUT : CHIEN;
            CHIEN:   next_state = OUT;
            OUT:     if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == OUT);
    end

    // Datapath. Syndromes are Horner evaluations of R at alpha and alpha^3,
    // fed from the top bit down so the final value is sum(R[i] * alpha^i).
    always_ff @(posedge clk) begin
        if (rst) begin
            r            <= '0;
            s1           <= 4'h0;
            s3           <= 4'h0;
            cnt          <= 4'd0;
            lambda1      <= 4'h0;
            lambda2      <= 4'h0;
            out_codeword <= '0;
            out_status   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r   <= in_codeword;
                        s1  <= 4'h0;
                        s3  <= 4'h0;
                        cnt <= 4'd14;
                    end
                end
                SYND: begin
                    s1  <= gf_mult(s1, 4'h2) ^ {3'b000, r[cnt]};
                    s3  <= gf_mult(s3, 4'h8) ^ {3'b000, r[cnt]};
                    cnt <= cnt - 4'd1;
                end
                CALC: begin
                    if (s1 == 4'h0) begin
                        // S1=0 with S3!=0 cannot come from one or two errors.
                        out_codeword <= r;
                        out_status   <= (s3 == 4'h0) ? 2'd0 : 2'd3;
                    end else begin
                        lambda1 <= s1;
                        lambda2 <= lam2_calc;
                    end
                end
                CHIEN: begin
                    if (root_match) begin
                        out_codeword <= r ^ chien_error_vector;
                        out_status   <= exp_roots;
                    end else begin
                        out_codeword <= r;
                        out_status   <= 2'd3;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = out_codeword[N-1:N-K];

`ifdef BCH_DEC_STATS_EN
    logic out_hs;
    assign out_hs = (state == OUT) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_corrected     <= 16'h0000;
            cnt_uncorrectable <= 16'h0000;
        end else if (out_hs) begin
            if (out_status == 2'd3) begin
                if (cnt_uncorrectable != 16'hFFFF) cnt_uncorrectable <= cnt_uncorrectable + 16'd1;
            end else if (out_status != 2'd0) begin
                if (cnt_corrected != 16'hFFFF) cnt_corrected <= cnt_corrected + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bch_dec_seq.sv
// Bench for bch_dec_seq: directed test-plan words, random codewords with 0..3 flips
// checked against a bounded-distance reference decoder, stall, stub and reset scenarios.
module tb_bch_dec_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_codeword;
    logic [3:0]  lambda1, lambda2;
    logic [14:0] chien_vec;
    logic        chien_found;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_codeword;
    logic [6:0]  out_data;
    logic [1:0]  out_status;
    logic        stub;
`ifdef BCH_DEC_STATS_EN
    logic [15:0] cnt_corrected, cnt_uncorrectable;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [14:0] GEN = 15'h01D1;

    always #5 clk = ~clk;

    // ---------------- GF(16) via exponent/log arithmetic ----------------
    function automatic logic [3:0] gexp(input int k);
        logic [4:0] v;
        v = 5'h01;
        for (int n = 0; n < (k % 15); n++) begin
            v = v << 1;
            if (v[4]) v = v ^ 5'h13;
        end
        return v[3:0];
    endfunction

    function automatic int glog(input logic [3:0] a);
        for (int k = 0; k < 15; k++) if (gexp(k) == a) return k;
        return 0;
    endfunction

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'h0 || b == 4'h0) return 4'h0;
        return gexp(glog(a) + glog(b));
    endfunction

    // External Chien block: error at i when Lambda(alpha^-i) == 0.
    function automatic logic [14:0] chien_real(input logic [3:0] l1, input logic [3:0] l2);
        logic [14:0] v;
        logic [3:0]  x;
        v = '0;
        for (int i = 0; i < 15; i++) begin
            x = gexp((15 - i) % 15);
            if ((4'h1 ^ gmul(l1, x) ^ gmul(l2, gmul(x, x))) == 4'h0) v[i] = 1'b1;
        end
        return v;
    endfunction

    assign chien_vec   = (stub && lambda2 != 4'h0) ? 15'h0001 : chien_real(lambda1, lambda2);
    assign chien_found = |chien_vec;

    // ---------------- reference decoder ----------------
    function automatic logic [7:0] syn(input logic [14:0] w);
        logic [3:0] a, b;
        a = 4'h0; b = 4'h0;
        for (int i = 0; i < 15; i++) if (w[i]) begin
            a = a ^ gexp(i);
            b = b ^ gexp(3 * i);
        end
        return {a, b};
    endfunction

    // Search all patterns of weight <= 2 that map the word onto a codeword.
    task automatic model(input logic [14:0] r, output logic [14:0] cw, output logic [1:0] st,
                         output logic [3:0] s1, output logic [3:0] l2);
        logic [7:0]  sy;
        logic [14:0] e;
        sy = syn(r);
        s1 = sy[7:4];
        cw = r; st = 2'd3; l2 = 4'h0;
        if (sy == 8'h00) st = 2'd0;
        else begin
            for (int i = 0; i < 15; i++) begin
                e = 15'h1 << i;
                if (st == 2'd3 && syn(r ^ e) == 8'h00) begin cw = r ^ e; st = 2'd1; end
            end
            for (int i = 0; i < 15; i++)
                for (int j = i + 1; j < 15; j++) begin
                    e = (15'h1 << i) | (15'h1 << j);
                    if (st == 2'd3 && syn(r ^ e) == 8'h00) begin
                        cw = r ^ e; st = 2'd2; l2 = gexp(i + j);
                    end
                end
        end
    endtask

    bch_dec_seq dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_codeword        (in_codeword),
        .lambda1            (lambda1),
        .lambda2            (lambda2),
        .chien_error_vector (chien_vec),
        .chien_error_found  (chien_found),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_codeword       (out_codeword),
        .out_data           (out_data),
        .out_status         (out_status)
`ifdef BCH_DEC_STATS_EN
        ,
        .cnt_corrected      (cnt_corrected),
        .cnt_uncorrectable  (cnt_uncorrectable)
`endif
    );

    // ---------------- stimulus helpers (no checking) ----------------
    // Called #1 after an edge; returns edges from accept to out_valid (100 = timeout).
    task automatic send_word(input logic [14:0] w, output int lat);
        int t;
        t = 0;
        in_codeword = w;
        in_valid    = 1'b1;
        while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        in_valid    = 1'b0;
        in_codeword = 15'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if ({lambda1, lambda2} !== 8'h00) begin errors++; $display("FAIL reset_lambda got=%h exp=00", {lambda1, lambda2}); end
        checks++; if ({out_codeword, out_status} !== 17'h0) begin errors++; $display("FAIL reset_out got=%h/%0d exp=0/0", out_codeword, out_status); end
    endtask

    task automatic test_directed();
        int lat;
        // single error at bit 3
        send_word(15'h0008, lat);
        checks++; if (lat !== 17) begin errors++; $display("FAIL d1_latency got=%0d exp=17", lat); end
        checks++; if (out_codeword !== 15'h0000) begin errors++; $display("FAIL d1_codeword got=%h exp=0000", out_codeword); end
        checks++; if (out_status !== 2'd1) begin errors++; $display("FAIL d1_status got=%0d exp=1", out_status); end
        checks++; if ({lambda1, lambda2} !== 8'h80) begin errors++; $display("FAIL d1_lambda got=%h exp=80", {lambda1, lambda2}); end
        release_out();
        // generator polynomial: clean codeword, lambdas untouched
        send_word(GEN, lat);
        checks++; if (lat !== 16) begin errors++; $display("FAIL d2_latency got=%0d exp=16", lat); end
        checks++; if (out_codeword !== GEN) begin errors++; $display("FAIL d2_codeword got=%h exp=%h", out_codeword, GEN); end
        checks++; if (out_data !== 7'h01) begin errors++; $display("FAIL d2_data got=%h exp=01", out_data); end
        checks++; if (out_status !== 2'd0) begin errors++; $display("FAIL d2_status got=%0d exp=0", out_status); end
        checks++; if ({lambda1, lambda2} !== 8'h80) begin errors++; $display("FAIL d2_lambda_held got=%h exp=80", {lambda1, lambda2}); end
        release_out();
        // two errors: bits 3 and 10
        send_word(15'h0408, lat);
        checks++; if (lat !== 17) begin errors++; $display("FAIL d3_latency got=%0d exp=17", lat); end
        checks++; if (out_codeword !== 15'h0000) begin errors++; $display("FAIL d3_codeword got=%h exp=0000", out_codeword); end
        checks++; if (out_status !== 2'd2) begin errors++; $display("FAIL d3_status got=%0d exp=2", out_status); end
        checks++; if (lambda2 === 4'h0) begin errors++; $display("FAIL d3_lambda2 got=%h exp=nonzero", lambda2); end
        release_out();
    endtask

    task automatic test_random();
        int lat, exp_lat;
        logic [6:0]  m;
        logic [14:0] cw, r, ecw;
        logic [1:0]  est;
        logic [3:0]  es1, el2;
        for (int n = 0; n < 24; n++) begin
            m  = 7'($urandom_range(0, 127));
            cw = '0;
            for (int k = 0; k < 7; k++) if (m[k]) cw = cw ^ (GEN << k);
            r = cw;
            for (int f = 0; f < int'($urandom_range(0, 3)); f++) r = r ^ (15'h1 << $urandom_range(0, 14));
            model(r, ecw, est, es1, el2);
            exp_lat = (es1 == 4'h0) ? 16 : 17;
            send_word(r, lat);
            checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd%0d_latency word=%h got=%0d exp=%0d", n, r, lat, exp_lat); end
            checks++; if (out_codeword !== ecw) begin errors++; $display("FAIL rnd%0d_codeword word=%h got=%h exp=%h", n, r, out_codeword, ecw); end
            checks++; if (out_data !== ecw[14:8]) begin errors++; $display("FAIL rnd%0d_data got=%h exp=%h", n, out_data, ecw[14:8]); end
            checks++; if (out_status !== est) begin errors++; $display("FAIL rnd%0d_status word=%h got=%0d exp=%0d", n, r, out_status, est); end
            if (es1 != 4'h0) begin
                checks++; if (lambda1 !== es1) begin errors++; $display("FAIL rnd%0d_lambda1 got=%h exp=%h", n, lambda1, es1); end
                if (est != 2'd3) begin
                    checks++; if (lambda2 !== el2) begin errors++; $display("FAIL rnd%0d_lambda2 got=%h exp=%h", n, lambda2, el2); end
                end
            end
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [14:0] ea, eb;
        logic [1:0]  sa, sb;
        logic [3:0]  t1, t2;
        model(15'h0408, ea, sa, t1, t2);
        model(GEN ^ 15'h4000, eb, sb, t1, t2);
        in_codeword = 15'h0408;
        in_valid    = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_codeword = GEN ^ 15'h4000;   // held valid while busy: must be ignored
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 17) begin errors++; $display("FAIL b2b_a_latency got=%0d exp=17", lat); end
        for (int c = 0; c < 5; c++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_stall%0d_valid got=%b exp=1", c, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall%0d_in_ready got=%b exp=0", c, in_ready); end
            checks++; if ({out_codeword, out_status} !== {ea, sa}) begin errors++; $display("FAIL b2b_stall%0d_out got=%h/%0d exp=%h/%0d", c, out_codeword, out_status, ea, sa); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_after_hs got=%b%b exp=10", in_ready, out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_b_accept got=%b exp=0", in_ready); end
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 17) begin errors++; $display("FAIL b2b_b_latency got=%0d exp=17", lat); end
        checks++; if ({out_codeword, out_status} !== {eb, sb}) begin errors++; $display("FAIL b2b_b_out got=%h/%0d exp=%h/%0d", out_codeword, out_status, eb, sb); end
        release_out();
    endtask

    task automatic test_stub();
        int lat;
        do_reset();
        stub = 1'b1;
        send_word(15'h0408, lat);
        checks++; if (lat !== 17) begin errors++; $display("FAIL stub_latency got=%0d exp=17", lat); end
        checks++; if (out_codeword !== 15'h0408) begin errors++; $display("FAIL stub_codeword got=%h exp=0408", out_codeword); end
        checks++; if (out_status !== 2'd3) begin errors++; $display("FAIL stub_status got=%0d exp=3", out_status); end
        release_out();
        stub = 1'b0;
        send_word(15'h0008, lat);
        checks++; if (out_status !== 2'd1) begin errors++; $display("FAIL stub_after_status got=%0d exp=1", out_status); end
        release_out();
`ifdef BCH_DEC_STATS_EN
        checks++; if (cnt_uncorrectable !== 16'd1) begin errors++; $display("FAIL stats_uncorr got=%0d exp=1", cnt_uncorrectable); end
        checks++; if (cnt_corrected !== 16'd1) begin errors++; $display("FAIL stats_corr got=%0d exp=1", cnt_corrected); end
`endif
    endtask

    task automatic test_reset_mid();
        int lat;
        in_codeword = 15'h0408;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rmid_hs got=%b%b exp=10", in_ready, out_valid); end
        checks++; if ({lambda1, lambda2, out_codeword, out_status} !== 25'h0) begin errors++; $display("FAIL rmid_regs got=%h exp=0", {lambda1, lambda2, out_codeword, out_status}); end
        send_word(15'h0008, lat);
        checks++; if (lat !== 17) begin errors++; $display("FAIL rmid_latency got=%0d exp=17", lat); end
        checks++; if ({out_codeword, out_status} !== {15'h0000, 2'd1}) begin errors++; $display("FAIL rmid_decode got=%h/%0d exp=0000/1", out_codeword, out_status); end
        // reset while stalled in OUT
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rout_hs got=%b%b exp=01", out_valid, in_ready); end
        checks++; if ({out_codeword, out_status} !== 17'h0) begin errors++; $display("FAIL rout_regs got=%h/%0d exp=0/0", out_codeword, out_status); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_codeword = '0; out_ready = 1'b0; stub = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_stub();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
